backscatter_sequencer: RTL and testbench

Packet-level controller for the ZigBee backscatter tag datapath, running on the 10 MHz derived clock. Watches the excitation trigger, waits a programmable offset, then enables the modulator for a fixed number of ZigBee symbols. During that window it fetches one tag bit per symbol from the data source over a ready/valid handshake. It presents that bit to the switch-gating logic, then holds a guard interval before re-arming.

---
 rtl/backscatter_pkg.sv | 25 ++
 rtl/backscatter_sequencer_trigger_sync.sv | 35 +++
 rtl/backscatter_sequencer.sv | 165 ++++++++++++++++
 tb/tb_backscatter_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/backscatter_pkg.sv
// Shared definitions for the backscatter tag packet sequencer: the state
// encoding, the default timing for a 10 MHz clock, and a counter-width helper.
package backscatter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_GUARD  = 2'd3
  } state_e;

  localparam int unsigned CLK_HZ     = 10_000_000;
  localparam int unsigned SYMBOL_US  = 16;

  localparam int unsigned DEF_DELAY_CYCLES    = 800;
  localparam int unsigned DEF_SYMBOL_CYCLES   = (CLK_HZ / 1_000_000) * SYMBOL_US;
  localparam int unsigned DEF_BITS_PER_PACKET = 32;
  localparam int unsigned DEF_GUARD_CYCLES    = 200;

  // A counter that runs 0..n-1 never needs more than $clog2(n) bits, floored at one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/backscatter_sequencer_trigger_sync.sv
// Two-flop synchronizer for the excitation trigger plus a one-cycle rising-edge
// pulse. No edge is reported until a real low sample has been seen after reset.
module trigger_sync (
  input  logic clock,
  input  logic reset,
  input  logic async_i,
  output logic rise_o
);

  logic       sync1_q;
  logic       sync2_q;
  logic       prev_q;
  logic [2:0] valid_q;

  // NOTE: state flops take non-blocking assignments so every flop samples the
  // pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      valid_q <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= {valid_q[1:0], 1'b1};
    end
  end

  // valid_q[2] marks that prev_q holds a real sample, so a trigger held high
  // through reset release does not look like a rising edge.
  assign rise_o = sync2_q & ~prev_q & valid_q[2];

endmodule

// File: rtl/backscatter_sequencer.sv
// Packet-level controller: trigger -> programmable delay -> one tag bit per
// ZigBee symbol with modulator enabled -> guard interval -> re-arm.
module backscatter_sequencer
  import backscatter_pkg::*;
#(
  parameter int unsigned DELAY_CYCLES    = DEF_DELAY_CYCLES,
  parameter int unsigned SYMBOL_CYCLES   = DEF_SYMBOL_CYCLES,
  parameter int unsigned BITS_PER_PACKET = DEF_BITS_PER_PACKET,
  parameter int unsigned GUARD_CYCLES    = DEF_GUARD_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic trigger_signal,
  input  logic enable,
  input  logic tag_bit,
  input  logic tag_bit_valid,
  output logic tag_bit_ready,
  output logic mod_enable,
  output logic tag_out,
  output logic symbol_strobe,
  output logic busy,
  output logic done,
  output logic underflow
);

  localparam int unsigned DW = cnt_width(DELAY_CYCLES);
  localparam int unsigned SW = cnt_width(SYMBOL_CYCLES);
  localparam int unsigned BW = cnt_width(BITS_PER_PACKET);
  localparam int unsigned GW = cnt_width(GUARD_CYCLES);

  state_e          state_q, state_d;
  logic [DW-1:0]   delay_cnt_q, delay_cnt_d;
  logic [SW-1:0]   sym_cnt_q, sym_cnt_d;
  logic [BW-1:0]   bit_idx_q, bit_idx_d;
  logic [GW-1:0]   guard_cnt_q, guard_cnt_d;

  logic mod_enable_q, mod_enable_d;
  logic tag_out_q, tag_out_d;
  logic symbol_strobe_q, symbol_strobe_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic underflow_q, underflow_d;

  logic trig_rise;
  logic last_delay, last_sym, last_bit, last_guard;
  logic fetch, accept, active_d;

  trigger_sync u_trigger_sync (
    .clock   (clock),
    .reset   (reset),
    .async_i (trigger_signal),
    .rise_o  (trig_rise)
  );

  assign last_delay = (delay_cnt_q == DW'(DELAY_CYCLES - 1));
  assign last_sym   = (sym_cnt_q == SW'(SYMBOL_CYCLES - 1));
  assign last_bit   = (bit_idx_q == BW'(BITS_PER_PACKET - 1));
  assign last_guard = (guard_cnt_q == GW'(GUARD_CYCLES - 1));

  // Request one bit on the last DELAY cycle and at the end of every symbol but the last.
  assign fetch = ((state_q == ST_DELAY) && last_delay) ||
                 ((state_q == ST_ACTIVE) && last_sym && !last_bit);
  assign accept = (state_q == ST_IDLE) && enable && trig_rise;

  assign tag_bit_ready = fetch;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d     = state_q;
    delay_cnt_d = delay_cnt_q;
    sym_cnt_d   = sym_cnt_q;
    bit_idx_d   = bit_idx_q;
    guard_cnt_d = guard_cnt_q;

    case (state_q)
      ST_IDLE: begin
        delay_cnt_d = '0;
        sym_cnt_d   = '0;
        bit_idx_d   = '0;
        guard_cnt_d = '0;
        if (accept) state_d = ST_DELAY;
      end
      ST_DELAY: begin
        if (last_delay) begin
          state_d   = ST_ACTIVE;
          sym_cnt_d = '0;
          bit_idx_d = '0;
        end else begin
          delay_cnt_d = delay_cnt_q + 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (last_sym) begin
          sym_cnt_d = '0;
          if (last_bit) begin
            state_d     = ST_GUARD;
            guard_cnt_d = '0;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          sym_cnt_d = sym_cnt_q + 1'b1;
        end
      end
      ST_GUARD: begin
        if (last_guard) state_d = ST_IDLE;
        else            guard_cnt_d = guard_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (!enable) state_d = ST_IDLE;

    // Outputs are registered from the next state so they line up with it.
    active_d        = (state_d == ST_ACTIVE);
    mod_enable_d    = active_d;
    tag_out_d       = active_d & (fetch ? (tag_bit & tag_bit_valid) : tag_out_q);
    symbol_strobe_d = active_d && (sym_cnt_d == '0);
    busy_d          = (state_d != ST_IDLE);
    done_d          = (state_q == ST_ACTIVE) && (state_d == ST_GUARD);

    underflow_d = underflow_q;
    if (accept)                      underflow_d = 1'b0;
    else if (fetch && !tag_bit_valid) underflow_d = 1'b1;
  end

  // NOTE: the asynchronous reset clears every flop, outputs included, so the
  // pins drop the moment reset rises rather than at the next edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      delay_cnt_q     <= '0;
      sym_cnt_q       <= '0;
      bit_idx_q       <= '0;
      guard_cnt_q     <= '0;
      mod_enable_q    <= 1'b0;
      tag_out_q       <= 1'b0;
      symbol_strobe_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      underflow_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      delay_cnt_q     <= delay_cnt_d;
      sym_cnt_q       <= sym_cnt_d;
      bit_idx_q       <= bit_idx_d;
      guard_cnt_q     <= guard_cnt_d;
      mod_enable_q    <= mod_enable_d;
      tag_out_q       <= tag_out_d;
      symbol_strobe_q <= symbol_strobe_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      underflow_q     <= underflow_d;
    end
  end

  assign mod_enable    = mod_enable_q;
  assign tag_out       = tag_out_q;
  assign symbol_strobe = symbol_strobe_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign underflow     = underflow_q;

endmodule

// File: tb/tb_backscatter_sequencer.sv
// Bench for backscatter_sequencer: a directed vector table, hand-written corner
// sequences and a randomized run against an offset-arithmetic packet model.
module tb_backscatter_sequencer;

  localparam int D     = 4;
  localparam int S     = 3;
  localparam int B     = 4;
  localparam int G     = 2;
  localparam int TOTAL = D + B * S + G;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic trigger_signal = 1'b0;
  logic enable = 1'b0;
  logic tag_bit = 1'b0;
  logic tag_bit_valid = 1'b0;
  logic tag_bit_ready, mod_enable, tag_out, symbol_strobe, busy, done, underflow;

  always #5 clock = ~clock;

  backscatter_sequencer #(
    .DELAY_CYCLES    (D),
    .SYMBOL_CYCLES   (S),
    .BITS_PER_PACKET (B),
    .GUARD_CYCLES    (G)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .trigger_signal (trigger_signal),
    .enable         (enable),
    .tag_bit        (tag_bit),
    .tag_bit_valid  (tag_bit_valid),
    .tag_bit_ready  (tag_bit_ready),
    .mod_enable     (mod_enable),
    .tag_out        (tag_out),
    .symbol_strobe  (symbol_strobe),
    .busy           (busy),
    .done           (done),
    .underflow      (underflow)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit src_bit[64];
  bit src_val[64];
  int fetch_no = 0;

  // Packet model: a packet is just a start cycle; everything else is offset arithmetic.
  int m_start = -1;
  bit m_bits[B];
  bit m_under = 1'b0;
  bit sa = 1'b1, sb = 1'b1, sc = 1'b1;

  typedef struct {
    bit         trig;
    logic [6:0] exp;
  } vec_t;
  vec_t tbl[32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic bit fetch_at(input int o);
    return (o == D - 1) ||
           (o >= D && o < D + B * S && (o - D) % S == S - 1 && (o - D) / S < B - 1);
  endfunction

  // Output vector order: busy, mod_enable, tag_out, symbol_strobe, ready, done, underflow.
  function automatic logic [6:0] model_out();
    int o;
    bit md, tg, st;
    if (m_start < 0) return {6'b0, m_under};
    o  = cyc - m_start;
    md = (o >= D) && (o < D + B * S);
    tg = md ? m_bits[(o - D) / S] : 1'b0;
    st = md && ((o - D) % S == 0);
    return {1'b1, md, tg, st, fetch_at(o), (o == D + B * S), m_under};
  endfunction

  function automatic logic [6:0] dut_out();
    return {busy, mod_enable, tag_out, symbol_strobe, tag_bit_ready, done, underflow};
  endfunction

  task automatic model_reset();
    cyc = 0;
    m_start = -1;
    m_under = 1'b0;
    sa = 1'b1;
    sb = 1'b1;
    sc = 1'b1;
  endtask

  // Advance the model across one edge using the inputs held during the cycle before it.
  task automatic model_edge(input bit t, input bit e, input bit b, input bit v);
    int p, o, idx;
    bit pulse;
    p = cyc - 1;
    pulse = sb & !sc;
    if (m_start >= 0) begin
      o = p - m_start;
      if (fetch_at(o)) begin
        idx = (o == D - 1) ? 0 : (o - D) / S + 1;
        m_bits[idx] = v ? b : 1'b0;
        if (!v) m_under = 1'b1;
      end
      if (!e || o == TOTAL - 1) m_start = -1;
    end else if (pulse && e) begin
      m_start = cyc;
      m_under = 1'b0;
    end
    sc = sb;
    sb = sa;
    sa = t;
  endtask

  task automatic drive_src();
    tag_bit       = src_bit[fetch_no % 64];
    tag_bit_valid = src_val[fetch_no % 64];
  endtask

  task automatic step();
    bit t, e, b, v, rdy;
    t = trigger_signal;
    e = enable;
    b = tag_bit;
    v = tag_bit_valid;
    rdy = tag_bit_ready;
    @(posedge clock);
    cyc++;
    model_edge(t, e, b, v);
    #1;
    if (rdy) fetch_no++;
    drive_src();
  endtask

  task automatic run_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      check(name, dut_out(), model_out());
      step();
    end
  endtask

  initial begin
    int c0, rises, dones;
    bit prev_busy;
    bit tag_pat[12];

    tag_pat = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    for (int i = 0; i < 64; i++) begin
      src_bit[i] = 1'($urandom);
      src_val[i] = 1'b1;
    end
    src_bit[0] = 1'b1;
    src_bit[1] = 1'b0;
    src_bit[2] = 1'b1;
    src_bit[3] = 1'b1;

    for (int c = 0; c < 32; c++) begin
      bit bz, mz, tz, sz, rz, dz;
      bz = (c >= 12) && (c <= 29);
      mz = (c >= 16) && (c <= 27);
      tz = mz ? tag_pat[c - 16] : 1'b0;
      sz = (c == 16) || (c == 19) || (c == 22) || (c == 25);
      rz = (c == 15) || (c == 18) || (c == 21) || (c == 24);
      dz = (c == 28);
      tbl[c].trig = (c >= 9) && (c <= 11);
      tbl[c].exp  = {bz, mz, tz, sz, rz, dz, 1'b0};
    end

    // Directed packet from the table.
    #22;
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    enable = 1'b1;
    fetch_no = 0;
    drive_src();
    for (int c = 0; c < 32; c++) begin
      check($sformatf("vec%0d", c), dut_out(), tbl[c].exp);
      trigger_signal = tbl[c].trig;
      step();
    end

    // Extra trigger edges during ACTIVE and GUARD are ignored.
    c0 = cyc;
    rises = 0;
    prev_busy = busy;
    for (int i = 0; i < 40; i++) begin
      check("retrig", dut_out(), model_out());
      if (busy && !prev_busy) rises++;
      prev_busy = busy;
      trigger_signal = (i inside {[1:2], [14:15], [19:20]});
      step();
    end
    check("one_packet", rises, 1);

    // Underflow on the third fetch, held through IDLE, cleared by the next trigger.
    fetch_no = 0;
    src_val[2] = 1'b0;
    drive_src();
    for (int i = 0; i < 30; i++) begin
      check("underflow_seq", dut_out(), model_out());
      if (i == 14) check("third_symbol_zero", dut_out(), 7'b1101001);
      trigger_signal = (i inside {[1:2]});
      step();
    end
    check("underflow_held", dut_out(), 7'b0000001);
    src_val[2] = 1'b1;
    for (int i = 0; i < 24; i++) begin
      check("underflow_clear_seq", dut_out(), model_out());
      if (i == 4) check("underflow_cleared", dut_out(), 7'b1000000);
      trigger_signal = (i inside {[1:2]});
      step();
    end

    // enable dropped in the second symbol aborts without done.
    dones = 0;
    for (int i = 0; i < 30; i++) begin
      check("abort_seq", dut_out(), model_out());
      if (i == 12) check("abort_idle", dut_out(), 7'b0000000);
      if (done) dones++;
      trigger_signal = (i inside {[1:2]});
      if (i == 11) enable = 1'b0;
      if (i == 13) enable = 1'b1;
      step();
    end
    check("abort_no_done", dones, 0);

    // Asynchronous reset mid-ACTIVE with trigger held high across release.
    for (int i = 0; i < 14; i++) begin
      check("pre_reset", dut_out(), model_out());
      trigger_signal = (i >= 1);
      step();
    end
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", dut_out(), 7'b0000000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_reset();
    fetch_no = 0;
    drive_src();
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      check("held_trigger", dut_out(), model_out());
      if (busy) rises++;
      step();
    end
    check("held_no_packet", rises, 0);
    trigger_signal = 1'b0;
    run_check(3, "retoggle_low");
    trigger_signal = 1'b1;
    run_check(3, "retoggle_high");
    check("retoggle_start", dut_out(), 7'b1000000);
    run_check(22, "retoggle_pkt");

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      check("random", dut_out(), model_out());
      if ($urandom_range(0, 7) == 0) trigger_signal = ~trigger_signal;
      enable        = ($urandom_range(0, 49) != 0);
      tag_bit       = 1'($urandom);
      tag_bit_valid = ($urandom_range(0, 9) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
